// File: rtl/qdma_sequencer.sv
// Round-robin sequencer that shares one QBUS bus-master engine between NREQ DMA requesters,
// splitting each granted block into single-word engine cycles and reporting progress.
module qdma_sequencer #(
    parameter int NREQ = 2,
    parameter int AW   = 22,
    parameter int CW   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*CW-1:0] req_count,
    output logic [NREQ-1:0]    req_grant,
    output logic               word_strobe,
    output logic               req_done,
    output logic               req_nxm,
    output logic               dma_read,
    output logic               dma_write,
    output logic [AW-1:0]      dma_addr,
    input  logic               dma_complete,
    input  logic               nxm,
    input  logic               bus_master
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_WAIT_IDLE,
        S_FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic            write_q, write_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic            dma_read_q, dma_read_d;
    logic            dma_write_q, dma_write_d;
    logic [AW-1:0]   dma_addr_q, dma_addr_d;
    logic            word_strobe_q, word_strobe_d;
    logic            req_done_q, req_done_d;
    logic            req_nxm_q, req_nxm_d;

    logic [AW-1:0]   addr_arr [NREQ];
    logic [CW-1:0]   count_arr [NREQ];
    logic            any_valid;
    logic            hi_hit;
    logic [IW-1:0]   hi_idx, lo_idx, pick_idx;

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign addr_arr[i]  = req_addr[i*AW +: AW];
        assign count_arr[i] = req_count[i*CW +: CW];
    end

    // Lowest valid index above the last grant wins; otherwise wrap to the lowest valid index.
    always_comb begin
        any_valid = 1'b0;
        hi_hit    = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                any_valid = 1'b1;
                lo_idx    = IW'(j);
                if (j > int'(last_q)) begin
                    hi_hit = 1'b1;
                    hi_idx = IW'(j);
                end
            end
        end
        pick_idx = hi_hit ? hi_idx : lo_idx;
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        last_d        = last_q;
        write_d       = write_q;
        addr_d        = addr_q;
        count_d       = count_q;
        err_d         = err_q;
        dma_read_d    = dma_read_q;
        dma_write_d   = dma_write_q;
        dma_addr_d    = dma_addr_q;
        word_strobe_d = 1'b0;
        req_done_d    = 1'b0;
        req_nxm_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    owner_d           = pick_idx;
                    write_d           = req_write[pick_idx];
                    addr_d            = addr_arr[pick_idx] & ~AW'(1);
                    count_d           = count_arr[pick_idx];
                    if (count_arr[pick_idx] == '0) begin
                        state_d    = S_FINISH;
                        req_done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                dma_addr_d  = addr_q;
                dma_read_d  = ~write_q;
                dma_write_d = write_q;
                state_d     = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // NXM takes precedence over a coincident completion.
                if (nxm) begin
                    dma_read_d  = 1'b0;
                    dma_write_d = 1'b0;
                    dma_addr_d  = '0;
                    req_nxm_d   = 1'b1;
                    err_d       = 1'b1;
                    state_d     = S_WAIT_IDLE;
                end else if (dma_complete) begin
                    dma_read_d    = 1'b0;
                    dma_write_d   = 1'b0;
                    dma_addr_d    = '0;
                    word_strobe_d = 1'b1;
                    addr_d        = addr_q + AW'(2);
                    count_d       = count_q - CW'(1);
                    state_d       = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (!bus_master) begin
                    if (err_q || count_q == '0 || !req_valid[owner_q]) begin
                        state_d    = S_FINISH;
                        req_done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_FINISH: begin
                grant_d = '0;
                last_d  = owner_q;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            owner_q       <= '0;
            last_q        <= IW'(NREQ - 1);
            write_q       <= 1'b0;
            addr_q        <= '0;
            count_q       <= '0;
            err_q         <= 1'b0;
            dma_read_q    <= 1'b0;
            dma_write_q   <= 1'b0;
            dma_addr_q    <= '0;
            word_strobe_q <= 1'b0;
            req_done_q    <= 1'b0;
            req_nxm_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            count_q       <= count_d;
            err_q         <= err_d;
            dma_read_q    <= dma_read_d;
            dma_write_q   <= dma_write_d;
            dma_addr_q    <= dma_addr_d;
            word_strobe_q <= word_strobe_d;
            req_done_q    <= req_done_d;
            req_nxm_q     <= req_nxm_d;
        end
    end

    assign req_grant   = grant_q;
    assign word_strobe = word_strobe_q;
    assign req_done    = req_done_q;
    assign req_nxm     = req_nxm_q;
    assign dma_read    = dma_read_q;
    assign dma_write   = dma_write_q;
    assign dma_addr    = dma_addr_q;

endmodule

// File: tb/tb_qdma_sequencer.sv
// Bench for qdma_sequencer: randomized blocks against a word-address / round-robin model,
// with a small bus-master engine model answering the DMA cycles.
module tb_qdma_sequencer;
    localparam int NREQ = 2;
    localparam int AW   = 22;
    localparam int CW   = 16;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*CW-1:0] req_count;
    logic [NREQ-1:0]    req_grant;
    logic               word_strobe, req_done, req_nxm, dma_read, dma_write;
    logic [AW-1:0]      dma_addr;
    logic               dma_complete, nxm, bus_master;

    int n_checks = 0;
    int n_fail   = 0;

    // engine model controls
    bit eng_en;
    int eng_word;
    int eng_nxm_word;
    bit eng_both;
    int eng_hold;

    // monitor records
    logic [AW-1:0]   mon_addr_q[$];
    logic            mon_wr_q[$];
    logic [NREQ-1:0] grant_log_q[$];
    int ws_cnt, done_cnt, nxm_cnt, both_cnt, cyc, last_nxm_cyc, last_done_cyc;
    logic prev_req;
    logic [NREQ-1:0] prev_grant;

    qdma_sequencer #(.NREQ(NREQ), .AW(AW), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_count(req_count), .req_grant(req_grant),
        .word_strobe(word_strobe), .req_done(req_done), .req_nxm(req_nxm),
        .dma_read(dma_read), .dma_write(dma_write), .dma_addr(dma_addr),
        .dma_complete(dma_complete), .nxm(nxm), .bus_master(bus_master)
    );

    always #25 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    // Engine model: answers one request per bus tenure, optional NXM on a chosen word.
    initial begin
        bus_master   = 1'b0;
        dma_complete = 1'b0;
        nxm          = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_en && reset_n && (dma_read || dma_write)) begin
                bus_master = 1'b1;
                eng_word++;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if (eng_word == eng_nxm_word) begin
                    nxm          = 1'b1;
                    dma_complete = eng_both;
                end else begin
                    dma_complete = 1'b1;
                end
                @(negedge clk);
                nxm          = 1'b0;
                dma_complete = 1'b0;
                repeat (eng_hold) @(negedge clk);
                bus_master = 1'b0;
            end
        end
    end

    initial begin
        prev_req   = 1'b0;
        prev_grant = '0;
        cyc        = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (dma_read && dma_write) both_cnt++;
            if ((dma_read || dma_write) && !prev_req) begin
                mon_addr_q.push_back(dma_addr);
                mon_wr_q.push_back(dma_write);
            end
            prev_req = dma_read || dma_write;
            if (req_grant != '0 && prev_grant == '0) grant_log_q.push_back(req_grant);
            prev_grant = req_grant;
            if (word_strobe) ws_cnt++;
            if (req_done) begin done_cnt++; last_done_cyc = cyc; end
            if (req_nxm) begin nxm_cnt++; last_nxm_cyc = cyc; end
        end
    end

    // Reference model: word k of a block sits at (start with bit0 cleared) + 2k, modulo 2^AW.
    function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] start, input int k);
        longint base;
        base = (longint'(start) / 2) * 2;
        return AW'((base + 2 * longint'(k)) % (longint'(1) << AW));
    endfunction

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        mon_addr_q.delete();
        mon_wr_q.delete();
        grant_log_q.delete();
        ws_cnt = 0; done_cnt = 0; nxm_cnt = 0; both_cnt = 0; eng_word = 0;
    endtask

    task automatic set_req(input int idx, input bit wr, input logic [AW-1:0] a, input int c);
        req_write[idx]            = wr;
        req_addr[idx*AW +: AW]    = a;
        req_count[idx*CW +: CW]   = CW'(c);
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (done_cnt >= target) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({req_grant, word_strobe, req_done, req_nxm, dma_read, dma_write, dma_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got grant=%b dma_r=%b dma_w=%b addr=%h, required all 0",
                     req_grant, dma_read, dma_write, dma_addr);
        end
        reset_n = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({req_grant, dma_read, dma_write, req_done} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got grant=%b rd=%b wr=%b done=%b, required all 0",
                     req_grant, dma_read, dma_write, req_done);
        end
    endtask

    task automatic test_single_read();
        int idx, c;
        bit wr, ok;
        logic [AW-1:0] a;
        for (int it = 0; it < 7; it++) begin
            if (it == 0) begin
                idx = 0; wr = 1'b0; a = AW'('o1000); c = 3;
            end else begin
                idx = $urandom_range(0, NREQ - 1); wr = 1'($urandom_range(0, 1));
                a = AW'($urandom); c = $urandom_range(0, 5);
            end
            clear_mon();
            set_req(idx, wr, a, c);
            req_valid[idx] = 1'b1;
            wait_done(1, ok);
            req_valid[idx] = 1'b0;
            repeat (2) tick();
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL block_done_timeout it=%0d: no req_done, required 1", it); end
            n_checks++;
            if (mon_addr_q.size() != c) begin
                n_fail++;
                $display("FAIL block_word_count it=%0d: got %0d cycles, required %0d", it, mon_addr_q.size(), c);
            end
            for (int k = 0; k < c && k < mon_addr_q.size(); k++) begin
                n_checks++;
                if (mon_addr_q[k] !== word_addr(a, k) || mon_wr_q[k] !== wr) begin
                    n_fail++;
                    $display("FAIL block_word it=%0d k=%0d: got addr=%o wr=%b, required addr=%o wr=%b",
                             it, k, mon_addr_q[k], mon_wr_q[k], word_addr(a, k), wr);
                end
            end
            n_checks++;
            if (ws_cnt != c || done_cnt != 1 || nxm_cnt != 0 || both_cnt != 0) begin
                n_fail++;
                $display("FAIL block_pulses it=%0d: got ws=%0d done=%0d nxm=%0d both=%0d, required ws=%0d done=1 nxm=0 both=0",
                         it, ws_cnt, done_cnt, nxm_cnt, both_cnt, c);
            end
            n_checks++;
            if (grant_log_q.size() != 1 || grant_log_q[0] !== NREQ'(1 << idx)) begin
                n_fail++;
                $display("FAIL block_grant it=%0d: got %0d grants first=%b, required 1 grant %b",
                         it, grant_log_q.size(), grant_log_q.size() > 0 ? grant_log_q[0] : '0, NREQ'(1 << idx));
            end
        end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0]   a [NREQ];
        logic [NREQ-1:0] exp_q[$];
        logic [AW-1:0]   exp_a_q[$];
        int last, g;
        bit ok;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        clear_mon();
        for (int i = 0; i < NREQ; i++) begin
            a[i] = AW'($urandom);
            set_req(i, 1'($urandom_range(0, 1)), a[i], 1);
        end
        last = NREQ - 1;
        for (int b = 0; b < 6; b++) begin
            g = rr_pick(last, '1);
            exp_q.push_back(NREQ'(1 << g));
            exp_a_q.push_back(word_addr(a[g], 0));
            last = g;
        end
        req_valid = '1;
        wait_done(6, ok);
        req_valid = '0;
        repeat (2) tick();
        n_checks++;
        if (!ok || grant_log_q.size() != 6) begin
            n_fail++;
            $display("FAIL rr_grant_count: got %0d grants (done=%0d), required 6", grant_log_q.size(), done_cnt);
        end
        for (int b = 0; b < 6 && b < grant_log_q.size() && b < mon_addr_q.size(); b++) begin
            n_checks++;
            if (grant_log_q[b] !== exp_q[b] || mon_addr_q[b] !== exp_a_q[b]) begin
                n_fail++;
                $display("FAIL rr_block b=%0d: got grant=%b addr=%o, required grant=%b addr=%o",
                         b, grant_log_q[b], mon_addr_q[b], exp_q[b], exp_a_q[b]);
            end
        end
    endtask

    task automatic test_nxm();
        int idx, c, w;
        bit wr, ok;
        logic [AW-1:0] a;
        for (int it = 0; it < 3; it++) begin
            if (it == 0) begin
                idx = 1; wr = 1'b1; a = AW'('o2000); c = 4; w = 2;
            end else begin
                idx = $urandom_range(0, NREQ - 1); wr = 1'($urandom_range(0, 1));
                a = AW'($urandom); c = $urandom_range(1, 6); w = $urandom_range(1, c);
            end
            eng_both = (it == 2);
            clear_mon();
            eng_nxm_word = w;
            set_req(idx, wr, a, c);
            req_valid[idx] = 1'b1;
            wait_done(1, ok);
            req_valid[idx] = 1'b0;
            repeat (2) tick();
            eng_nxm_word = 0;
            eng_both = 1'b0;
            n_checks++;
            if (!ok || mon_addr_q.size() != w) begin
                n_fail++;
                $display("FAIL nxm_words it=%0d: got %0d cycles done=%0d, required %0d cycles", it, mon_addr_q.size(), done_cnt, w);
            end
            for (int k = 0; k < w && k < mon_addr_q.size(); k++) begin
                n_checks++;
                if (mon_addr_q[k] !== word_addr(a, k)) begin
                    n_fail++;
                    $display("FAIL nxm_addr it=%0d k=%0d: got %o, required %o", it, k, mon_addr_q[k], word_addr(a, k));
                end
            end
            n_checks++;
            if (ws_cnt != w - 1 || nxm_cnt != 1 || done_cnt != 1 || !(last_nxm_cyc < last_done_cyc)) begin
                n_fail++;
                $display("FAIL nxm_pulses it=%0d: got ws=%0d nxm=%0d done=%0d nxm_cyc=%0d done_cyc=%0d, required ws=%0d nxm=1 done=1 nxm before done",
                         it, ws_cnt, nxm_cnt, done_cnt, last_nxm_cyc, last_done_cyc, w - 1);
            end
        end
    endtask

    task automatic test_wrap_zero();
        logic [AW-1:0] a_t [3];
        int c_t [3];
        bit ok;
        a_t[0] = AW'('h3FFFFE); c_t[0] = 2;
        a_t[1] = AW'('o4000);   c_t[1] = 0;
        a_t[2] = AW'('o1001);   c_t[2] = 1;
        for (int it = 0; it < 3; it++) begin
            clear_mon();
            set_req(it % NREQ, 1'(it % 2), a_t[it], c_t[it]);
            req_valid[it % NREQ] = 1'b1;
            wait_done(1, ok);
            req_valid[it % NREQ] = 1'b0;
            repeat (2) tick();
            n_checks++;
            if (!ok || mon_addr_q.size() != c_t[it] || ws_cnt != c_t[it] || done_cnt != 1) begin
                n_fail++;
                $display("FAIL edge_block it=%0d: got cycles=%0d ws=%0d done=%0d, required cycles=%0d ws=%0d done=1",
                         it, mon_addr_q.size(), ws_cnt, done_cnt, c_t[it], c_t[it]);
            end
            for (int k = 0; k < c_t[it] && k < mon_addr_q.size(); k++) begin
                n_checks++;
                if (mon_addr_q[k] !== word_addr(a_t[it], k)) begin
                    n_fail++;
                    $display("FAIL edge_addr it=%0d k=%0d: got %h, required %h", it, k, mon_addr_q[k], word_addr(a_t[it], k));
                end
            end
        end
    endtask

    task automatic test_abort();
        bit ok, seen;
        logic [AW-1:0] a;
        a = AW'($urandom);
        clear_mon();
        set_req(0, 1'b0, a, 5);
        req_valid[0] = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            tick();
            seen = (mon_addr_q.size() >= 1);
        end
        req_valid[0] = 1'b0;
        wait_done(1, ok);
        repeat (2) tick();
        n_checks++;
        if (!seen || !ok || mon_addr_q.size() != 1 || ws_cnt != 1 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL abort_block: got cycles=%0d ws=%0d done=%0d, required cycles=1 ws=1 done=1",
                     mon_addr_q.size(), ws_cnt, done_cnt);
        end
    endtask

    task automatic test_handshake();
        bit ok, seen_bm, seen_fall, seen_rd;
        int n;
        clear_mon();
        eng_hold = 50;
        set_req(0, 1'b0, AW'($urandom), 2);
        req_valid[0] = 1'b1;
        seen_bm = 1'b0; seen_fall = 1'b0; seen_rd = 1'b0; n = 0;
        for (int t = 0; t < 100 && !seen_bm; t++) begin tick(); seen_bm = bus_master; end
        for (int t = 0; t < 200 && seen_bm && !seen_fall; t++) begin tick(); seen_fall = !bus_master; end
        n = 1;
        n_checks++;
        if (!seen_fall || dma_read !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_fall: got bm_fall=%b dma_read=%b, required fall seen and dma_read 0", seen_fall, dma_read);
        end
        for (int t = 0; t < 20 && !seen_rd; t++) begin tick(); n++; seen_rd = dma_read; end
        n_checks++;
        if (!seen_rd || n != 2) begin
            n_fail++;
            $display("FAIL hs_gap: got dma_read after %0d edges (seen=%b), required 2", n, seen_rd);
        end
        wait_done(1, ok);
        req_valid[0] = 1'b0;
        repeat (2) tick();
        eng_hold = 0;
        n_checks++;
        if (!ok || mon_addr_q.size() != 2 || ws_cnt != 2) begin
            n_fail++;
            $display("FAIL hs_block: got cycles=%0d ws=%0d done=%0d, required 2 2 1", mon_addr_q.size(), ws_cnt, done_cnt);
        end
    endtask

    task automatic test_reset_midop();
        bit seen, ok;
        seen = 1'b0;
        clear_mon();
        eng_en = 1'b0;
        set_req(1, 1'b1, AW'($urandom), 3);
        set_req(0, 1'b0, AW'($urandom), 1);
        req_valid = 2'b10;
        for (int t = 0; t < 50 && !seen; t++) begin tick(); seen = dma_write; end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (!seen || {req_grant, word_strobe, req_done, req_nxm, dma_read, dma_write, dma_addr} !== '0) begin
            n_fail++;
            $display("FAIL midop_reset_outputs: got grant=%b rd=%b wr=%b addr=%h (reached=%b), required all 0",
                     req_grant, dma_read, dma_write, dma_addr, seen);
        end
        req_valid = 2'b11;
        repeat (3) tick();
        reset_n = 1'b1;
        eng_en = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin tick(); seen = (req_grant != '0); end
        n_checks++;
        if (!seen || req_grant !== 2'b01 || done_cnt != 0 || nxm_cnt != 0 || ws_cnt != 0) begin
            n_fail++;
            $display("FAIL midop_regrant: got grant=%b done=%0d nxm=%0d ws=%0d, required grant=01 and no pulses",
                     req_grant, done_cnt, nxm_cnt, ws_cnt);
        end
        req_valid[1] = 1'b0;
        wait_done(1, ok);
        req_valid = '0;
        repeat (2) tick();
        n_checks++;
        if (!ok || ws_cnt != 1) begin
            n_fail++;
            $display("FAIL midop_after: got done=%0d ws=%0d, required done=1 ws=1", done_cnt, ws_cnt);
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        req_valid    = '0;
        req_write    = '0;
        req_addr     = '0;
        req_count    = '0;
        eng_en       = 1'b1;
        eng_nxm_word = 0;
        eng_both     = 1'b0;
        eng_hold     = 0;
        ws_cnt = 0; done_cnt = 0; nxm_cnt = 0; both_cnt = 0;
        last_nxm_cyc = 0; last_done_cyc = 0; eng_word = 0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_nxm();
        test_wrap_zero();
        test_abort();
        test_handshake();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
